// File: rtl/mem_port_arbiter.sv
// Single-outstanding arbiter sharing one memory port between instruction fetch and load/store.
// Define RR_ARB_EN for round-robin tie-breaking; otherwise data always wins a tie.
module mem_port_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 15
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                if_req,
  input  logic [ADDR_W-1:0]   if_addr,
  output logic                if_gnt,
  output logic                if_rvalid,
  output logic [DATA_W-1:0]   if_rdata,
  output logic                if_err,
  input  logic                d_req,
  input  logic                d_we,
  input  logic [DATA_W/8-1:0] d_be,
  input  logic [ADDR_W-1:0]   d_addr,
  input  logic [DATA_W-1:0]   d_wdata,
  output logic                d_gnt,
  output logic                d_rvalid,
  output logic [DATA_W-1:0]   d_rdata,
  output logic                d_err,
  output logic                mem_req,
  output logic                mem_we,
  output logic [DATA_W/8-1:0] mem_be,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  input  logic                mem_rvalid,
  input  logic [DATA_W-1:0]   mem_rdata,
  output logic [1:0]          dbg_state
);

  localparam int BE_W  = DATA_W / 8;
  localparam int CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT);

  // Handshake: a requester holds req (and its fields) until its one-cycle gnt;
  // exactly one rvalid pulse per grant follows, carrying rdata/err for that owner.
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t            state;
  state_t            state_next;
  logic              owner_d;
  logic [CNT_W-1:0]  cnt;
  logic              pick_d;
  logic              grant;
  logic              timeout_hit;
  logic              go_resp;
  logic [DATA_W-1:0] resp_data;

`ifdef RR_ARB_EN
  logic rr_d;

  assign pick_d = d_req & (~if_req | rr_d);

  // Favour whichever requester was not granted last.
  always_ff @(posedge clk) begin
    if (rst) begin
      rr_d <= 1'b1;
    end else if (grant) begin
      rr_d <= ~pick_d;
    end
  end
`else
  assign pick_d = d_req;
`endif

  assign grant       = (state == IDLE) && (if_req || d_req);
  assign timeout_hit = (state == WAIT) && !mem_rvalid && (cnt == CNT_MAX);
  assign go_resp     = ((state == ISSUE) || (state == WAIT)) && (state_next == RESP);
  assign resp_data   = timeout_hit ? '0 : mem_rdata;
  assign dbg_state   = state;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:  if (if_req || d_req) state_next = ISSUE;
      ISSUE: state_next = mem_rvalid ? RESP : WAIT;
      WAIT:  if (mem_rvalid || cnt == CNT_MAX) state_next = RESP;
      RESP:  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      owner_d   <= 1'b0;
      cnt       <= '0;
      if_gnt    <= 1'b0;
      d_gnt     <= 1'b0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_be    <= '0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      if_rvalid <= 1'b0;
      if_rdata  <= '0;
      if_err    <= 1'b0;
      d_rvalid  <= 1'b0;
      d_rdata   <= '0;
      d_err     <= 1'b0;
    end else begin
      if_gnt  <= grant & ~pick_d;
      d_gnt   <= grant & pick_d;
      mem_req <= grant;

      if (grant) begin
        owner_d   <= pick_d;
        mem_we    <= pick_d & d_we;
        mem_be    <= pick_d ? d_be : BE_W'(0);
        mem_addr  <= pick_d ? d_addr : if_addr;
        mem_wdata <= pick_d ? d_wdata : '0;
        cnt       <= '0;
      end else if (((state == ISSUE) || (state == WAIT)) && (cnt != CNT_MAX)) begin
        cnt <= cnt + CNT_W'(1);
      end

      // Response fields are zero outside the owner's rvalid cycle.
      if_rvalid <= go_resp & ~owner_d;
      d_rvalid  <= go_resp & owner_d;
      if_rdata  <= (go_resp & ~owner_d) ? resp_data : '0;
      d_rdata   <= (go_resp & owner_d) ? resp_data : '0;
      if_err    <= go_resp & ~owner_d & timeout_hit;
      d_err     <= go_resp & owner_d & timeout_hit;
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a small behavioural RAM responder.
module tb_mem_port_arbiter;

  logic        clk;
  logic        rst;
  logic        if_req;
  logic [31:0] if_addr;
  logic        if_gnt, if_rvalid, if_err;
  logic [31:0] if_rdata;
  logic        d_req, d_we;
  logic [3:0]  d_be;
  logic [31:0] d_addr, d_wdata;
  logic        d_gnt, d_rvalid, d_err;
  logic [31:0] d_rdata;
  logic        mem_req, mem_we;
  logic [3:0]  mem_be;
  logic [31:0] mem_addr, mem_wdata;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;
  logic [1:0]  dbg_state;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;

  // responder controls
  bit          resp_en = 1'b1;
  int          resp_k = 1;
  bit          late_pulse = 1'b0;
  bit          pend = 1'b0;
  int          dly = 0;
  logic [31:0] p_rdata = '0;
  logic [31:0] ram [0:15];

  wire [139:0] all_out = {if_gnt, if_rvalid, if_err, if_rdata, d_gnt, d_rvalid, d_err, d_rdata,
                          mem_req, mem_we, mem_be, mem_addr, mem_wdata};

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(15)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_rvalid(if_rvalid),
    .if_rdata(if_rdata), .if_err(if_err),
    .d_req(d_req), .d_we(d_we), .d_be(d_be), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata), .d_err(d_err),
    .mem_req(mem_req), .mem_we(mem_we), .mem_be(mem_be), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .dbg_state(dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // RAM model: sees mem_req mid-cycle and answers k cycles later
  always @(negedge clk) begin
    mem_rvalid = 1'b0;
    mem_rdata  = '0;
    if (rst) begin
      pend = 1'b0;
    end else begin
      if (mem_req && resp_en) begin
        pend = 1'b1;
        dly  = resp_k;
        if (mem_we) begin
          for (int b = 0; b < 4; b++)
            if (mem_be[b]) ram[mem_addr[5:2]][8*b +: 8] = mem_wdata[8*b +: 8];
          p_rdata = mem_wdata;
        end else begin
          p_rdata = ram[mem_addr[5:2]];
        end
      end
      if (late_pulse) begin
        mem_rvalid = 1'b1;
        mem_rdata  = 32'hDEADBEEF;
        late_pulse = 1'b0;
      end else if (pend) begin
        if (dly == 0) begin
          mem_rvalid = 1'b1;
          mem_rdata  = p_rdata;
          pend       = 1'b0;
        end else begin
          dly = dly - 1;
        end
      end
    end
  end

  // driver tasks
  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic wait_gnt(input bit is_d, output int lat);
    lat = -1;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      if ((is_d ? d_gnt : if_gnt) === 1'b1) begin
        lat = i;
        break;
      end
    end
  endtask

  task automatic wait_rvalid(input bit is_d, output int lat, output logic [31:0] rd, output logic er);
    lat = -1;
    rd  = 'x;
    er  = 1'bx;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      if ((is_d ? d_rvalid : if_rvalid) === 1'b1) begin
        lat = i;
        rd  = is_d ? d_rdata : if_rdata;
        er  = is_d ? d_err : if_err;
        break;
      end
    end
  endtask

  // scenarios
  task automatic test_reset();
    do_reset();
    n_cmp++;
    if (all_out !== '0) begin
      n_bad++;
      $display("FAIL reset_outputs: got %h expected 0", all_out);
    end
    n_cmp++;
    if (dbg_state !== 2'd0) begin
      n_bad++;
      $display("FAIL reset_state: got %0d expected 0", dbg_state);
    end
  endtask

  task automatic test_fetch();
    int lat;
    logic [31:0] rd;
    logic er;
    resp_en = 1'b1;
    resp_k  = 1;
    if_addr = 32'h4;
    if_req  = 1'b1;
    wait_gnt(1'b0, lat);
    if_req = 1'b0;
    n_cmp++;
    if (lat !== 1) begin
      n_bad++;
      $display("FAIL fetch_gnt_latency: got %0d expected 1", lat);
    end
    n_cmp++;
    if ({mem_req, mem_we, mem_be, mem_addr} !== {1'b1, 1'b0, 4'h0, 32'h4}) begin
      n_bad++;
      $display("FAIL fetch_mem_fields: got req=%b we=%b be=%h addr=%h expected 1 0 0 00000004",
               mem_req, mem_we, mem_be, mem_addr);
    end
    wait_rvalid(1'b0, lat, rd, er);
    n_cmp++;
    if (lat !== 2 || rd !== 32'h00A00093 || er !== 1'b0) begin
      n_bad++;
      $display("FAIL fetch_resp: got lat=%0d rdata=%h err=%b expected 2 00a00093 0", lat, rd, er);
    end
    n_cmp++;
    if ({d_gnt, d_rvalid, d_err, d_rdata} !== '0) begin
      n_bad++;
      $display("FAIL fetch_data_port_quiet: got %h expected 0", {d_gnt, d_rvalid, d_err, d_rdata});
    end
    @(negedge clk);
    n_cmp++;
    if (dbg_state !== 2'd0 || if_rvalid !== 1'b0) begin
      n_bad++;
      $display("FAIL fetch_back_idle: got state=%0d rvalid=%b expected 0 0", dbg_state, if_rvalid);
    end
  endtask

  task automatic test_store_load();
    int lat;
    logic [31:0] rd;
    logic er;
    resp_k  = 1;
    d_we    = 1'b1;
    d_be    = 4'hF;
    d_addr  = 32'h0;
    d_wdata = 32'd100;
    d_req   = 1'b1;
    wait_gnt(1'b1, lat);
    d_req = 1'b0;
    n_cmp++;
    if ({mem_we, mem_be, mem_wdata} !== {1'b1, 4'hF, 32'd100}) begin
      n_bad++;
      $display("FAIL store_mem_fields: got we=%b be=%h wdata=%0d expected 1 f 100", mem_we, mem_be, mem_wdata);
    end
    wait_rvalid(1'b1, lat, rd, er);
    n_cmp++;
    if (lat !== 2 || er !== 1'b0) begin
      n_bad++;
      $display("FAIL store_resp: got lat=%0d err=%b expected 2 0", lat, er);
    end
    @(negedge clk);
    d_we    = 1'b0;
    d_wdata = 32'h0;
    d_req   = 1'b1;
    wait_gnt(1'b1, lat);
    d_req = 1'b0;
    n_cmp++;
    if (mem_we !== 1'b0) begin
      n_bad++;
      $display("FAIL load_mem_we: got %b expected 0", mem_we);
    end
    wait_rvalid(1'b1, lat, rd, er);
    n_cmp++;
    if (rd !== 32'd100 || er !== 1'b0) begin
      n_bad++;
      $display("FAIL load_rdata: got %0d err=%b expected 100 0", rd, er);
    end
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    int n;
    int g_cyc [3];
    logic [2:0] order;
    logic [2:0] exp_order;
`ifdef RR_ARB_EN
    exp_order = 3'b101;
`else
    exp_order = 3'b111;
`endif
    do_reset();
    resp_k  = 0;
    if_addr = 32'h4;
    d_addr  = 32'h0;
    d_we    = 1'b0;
    if_req  = 1'b1;
    d_req   = 1'b1;
    n = 0;
    order = '0;
    for (int i = 0; i < 40 && n < 3; i++) begin
      @(negedge clk);
      if (if_gnt === 1'b1 && d_gnt === 1'b1) begin
        n_cmp++;
        n_bad++;
        $display("FAIL b2b_both_gnt: got if_gnt=1 d_gnt=1 expected one-hot");
      end
      if (if_gnt === 1'b1 || d_gnt === 1'b1) begin
        order[2-n] = d_gnt;
        g_cyc[n] = cyc;
        n++;
      end
    end
    if_req = 1'b0;
    d_req  = 1'b0;
    n_cmp++;
    if (n !== 3 || order !== exp_order) begin
      n_bad++;
      $display("FAIL b2b_order: got n=%0d order=%b expected 3 %b", n, order, exp_order);
    end
    n_cmp++;
    if (n == 3 && (g_cyc[1] - g_cyc[0] !== 3 || g_cyc[2] - g_cyc[1] !== 3)) begin
      n_bad++;
      $display("FAIL b2b_spacing: got %0d,%0d expected 3,3", g_cyc[1] - g_cyc[0], g_cyc[2] - g_cyc[1]);
    end
    repeat (3) @(negedge clk);
    n_cmp++;
    if (dbg_state !== 2'd0) begin
      n_bad++;
      $display("FAIL b2b_drain: got state=%0d expected 0", dbg_state);
    end
  endtask

  task automatic test_timeout();
    int lat;
    logic [31:0] rd;
    logic er;
    int seen;
    resp_en = 1'b0;
    d_we    = 1'b0;
    d_addr  = 32'h8;
    d_req   = 1'b1;
    wait_gnt(1'b1, lat);
    d_req = 1'b0;
    wait_rvalid(1'b1, lat, rd, er);
    n_cmp++;
    if (lat !== 16 || er !== 1'b1 || rd !== 32'h0) begin
      n_bad++;
      $display("FAIL timeout_resp: got lat=%0d err=%b rdata=%h expected 16 1 0", lat, er, rd);
    end
    @(negedge clk);
    late_pulse = 1'b1;
    seen = 0;
    repeat (3) begin
      @(negedge clk);
      if ({if_gnt, if_rvalid, if_err, d_gnt, d_rvalid, d_err, mem_req} !== '0) seen++;
    end
    n_cmp++;
    if (seen !== 0 || dbg_state !== 2'd0) begin
      n_bad++;
      $display("FAIL timeout_late_resp: got %0d active cycles state=%0d expected 0 0", seen, dbg_state);
    end
    resp_en = 1'b1;
  endtask

  task automatic test_reset_in_wait();
    int lat;
    logic [31:0] rd;
    logic er;
    resp_en = 1'b0;
    if_addr = 32'h4;
    if_req  = 1'b1;
    wait_gnt(1'b0, lat);
    if_req = 1'b0;
    repeat (2) @(negedge clk);
    n_cmp++;
    if (dbg_state !== 2'd2) begin
      n_bad++;
      $display("FAIL rst_wait_precond: got state=%0d expected 2", dbg_state);
    end
    rst = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (all_out !== '0 || dbg_state !== 2'd0) begin
      n_bad++;
      $display("FAIL rst_wait_abort: got out=%h state=%0d expected 0 0", all_out, dbg_state);
    end
    rst = 1'b0;
    resp_en = 1'b1;
    resp_k  = 1;
    if_req  = 1'b1;
    wait_gnt(1'b0, lat);
    if_req = 1'b0;
    wait_rvalid(1'b0, lat, rd, er);
    n_cmp++;
    if (lat !== 2 || rd !== 32'h00A00093 || er !== 1'b0) begin
      n_bad++;
      $display("FAIL rst_wait_refetch: got lat=%0d rdata=%h err=%b expected 2 00a00093 0", lat, rd, er);
    end
    @(negedge clk);
  endtask

  task automatic test_k0();
    int lat;
    int lat2;
    logic [31:0] rd;
    logic er;
    resp_k = 0;
    d_we   = 1'b0;
    d_addr = 32'h4;
    d_req  = 1'b1;
    wait_gnt(1'b1, lat);
    wait_rvalid(1'b1, lat, rd, er);
    n_cmp++;
    if (lat !== 1 || rd !== 32'h00A00093) begin
      n_bad++;
      $display("FAIL k0_resp: got lat=%0d rdata=%h expected 1 00a00093", lat, rd);
    end
    wait_gnt(1'b1, lat2);
    d_req = 1'b0;
    n_cmp++;
    if (lat + lat2 !== 3) begin
      n_bad++;
      $display("FAIL k0_regrant: got %0d expected 3", lat + lat2);
    end
    wait_rvalid(1'b1, lat, rd, er);
    @(negedge clk);
  endtask

  initial begin
    rst     = 1'b1;
    if_req  = 1'b0;
    if_addr = '0;
    d_req   = 1'b0;
    d_we    = 1'b0;
    d_be    = '0;
    d_addr  = '0;
    d_wdata = '0;
    for (int i = 0; i < 16; i++) ram[i] = 32'h0;
    ram[1] = 32'h00A00093;
    @(negedge clk);
    test_reset();
    test_fetch();
    test_store_load();
    test_back_to_back();
    test_timeout();
    test_reset_in_wait();
    test_k0();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Shares one single-port unified memory between the core's instruction-fetch and load/store requesters, so a single RAM can back both instruction and data memory. It sits between the core and the memory macro, grants one outstanding transaction at a time, routes the response back to its owner, and bounds every access with a timeout counter.

## Interface
- ADDR_W, 32, address width for both requesters and the memory port
- DATA_W, 32, data width; byte enables are DATA_W/8 bits
- TIMEOUT, 15, number of cycles allowed in ISSUE+WAIT before an access is aborted with an error; must be ≥1
- clk  in  1  clock; all logic updates on rising edge
- rst  in  1  reset, synchronous and active-high
- if_req  in  1  fetch request; held high with if_addr stable until if_gnt
- if_addr  in  ADDR_W  fetch address
- if_gnt  out  1  fetch request captured; one-cycle pulse
- if_rvalid  out  1  fetch response valid; one-cycle pulse
- if_rdata  out  DATA_W  fetch data; valid only with if_rvalid
- if_err  out  1  fetch timed out; valid only with if_rvalid
- d_req  in  1  data request; held high with all d_* fields stable until d_gnt
- d_we  in  1  1 = store, 0 = load
- d_be  in  DATA_W/8  store byte enables
- d_addr  in  ADDR_W  data address
- d_wdata  in  DATA_W  store data
- d_gnt, d_rvalid, d_rdata, d_err  out  1/1/DATA_W/1  same meaning as the if_* outputs, for the data port
- mem_req  out  1  memory access strobe; one-cycle pulse
- mem_we, mem_be, mem_addr, mem_wdata  out  1/DATA_W/8/ADDR_W/DATA_W  latched fields of the granted request; mem_we=0 and mem_be=0 for fetches
- mem_rvalid  in  1  memory completion for loads, fetches, and stores
- mem_rdata  in  DATA_W  read data; valid with mem_rvalid

## Operation
- States: IDLE, ISSUE, WAIT, RESP. Only one transaction is in flight at a time.
- IDLE: if any request is high, latch the winner's fields and owner ID, clear the timeout counter, and go to ISSUE. Otherwise stay in IDLE.
- ISSUE (1 cycle):
  - mem_req=1 and the owner's gnt=1.
  - If mem_rvalid=1, capture mem_rdata and go to RESP. Otherwise go to WAIT.
- WAIT:
  - On mem_rvalid=1, capture mem_rdata, set err=0, and go to RESP.
  - If the counter reaches TIMEOUT first, set rdata=0, set err=1, and go to RESP.
  - The counter increments in every ISSUE and WAIT cycle. Its width is $clog2(TIMEOUT+1). It saturates and never wraps.
- RESP (1 cycle): the owner's rvalid=1 with captured rdata/err, then go to IDLE. Stores also get rvalid, with rdata as returned by memory.
- Arbitration happens only in IDLE. A request that is still held high during ISSUE, WAIT, or RESP is not re-granted until the arbiter returns to IDLE.
- mem_rvalid is ignored in IDLE and RESP. Any response arriving after a timeout is discarded.
- Non-owner outputs (gnt, rvalid, err) stay 0 at all times. Non-owner rdata is 0.

## Timing
- Reset values:
  - State = IDLE.
  - All gnt, rvalid, err, and mem_req outputs are 0.
  - All rdata, mem_addr, mem_wdata, mem_be, and mem_we outputs are 0.
  - The round-robin pointer selects data.
- Reset mid-transaction aborts immediately. No rvalid is produced for the dropped access.
- Request high in IDLE cycle C gives gnt and mem_req in C+1.
- mem_rvalid in cycle C+1+k (k≥0) gives rvalid in C+2+k, back in IDLE at C+3+k.
- Minimum occupancy is 3 cycles per access (k=0). New arbitration is possible in the cycle that follows RESP.
- Timeout: with no mem_rvalid, rvalid with err=1 appears in cycle C+1+TIMEOUT+1.
- All outputs are registered. No combinational path exists from any input to any output.

## Configuration
- RR_ARB_EN defined: round-robin arbitration.
  - On a tie, the requester not granted last wins.
  - The pointer updates at each grant and resets to favour data.
- RR_ARB_EN undefined: fixed priority, data over fetch, on every tie.
  - No pointer register exists.

## Test plan
- Single fetch, if_addr=0x4, memory returns 0x00A00093 with k=1:
  - if_gnt in C+1, if_rvalid in C+3 with if_rdata=0x00A00093 and if_err=0.
  - d_* outputs stay 0.
- Store d_addr=0x0, d_wdata=100, d_be=0xF, then load 0x0 (model RAM, k=1):
  - mem_we=1 and mem_be=0xF on the store.
  - The load returns d_rdata=100.
- Simultaneous if_req and d_req held for 3 back-to-back grants:
  - Without RR_ARB_EN: grant order d, d, d.
  - With RR_ARB_EN: grant order d, if, d.
- Memory never asserts mem_rvalid with TIMEOUT=15:
  - d_rvalid=1 and d_err=1 and d_rdata=0 exactly 16 cycles after d_gnt.
  - A late mem_rvalid afterwards produces no output.
- rst asserted in WAIT:
  - Next cycle all outputs are 0 and the state is IDLE.
  - A fetch issued after release is served normally.
- k=0 response (mem_rvalid in the ISSUE cycle):
  - rvalid appears the cycle after gnt.
  - The next grant appears 3 cycles after the previous one.
